// File: rtl/rand_arb_pkg.sv
// Shared definitions for the rand_arb random-number scheduler: FSM states,
// counter widths and the requester-count limit.
package rand_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WARM,
        ST_RUN
    } arb_state_t;

    localparam int WARM_W   = 8;
    localparam int GAP_W    = 4;
    localparam int NREQ_MAX = 8;

    localparam logic [GAP_W-1:0] GAP_SAT = '1;

    // Pointer width for a requester count, clamped to the supported range.
    function automatic int ptr_width(input int n);
        int c;
        c = (n < 2) ? 2 : ((n > NREQ_MAX) ? NREQ_MAX : n);
        return $clog2(c);
    endfunction

endpackage

// File: rtl/rand_arb_rr_pick.sv
// Combinational round-robin picker: one-hot select of the first request bit
// at or after ptr, wrapping modulo NREQ.
module rr_pick
    import rand_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] sel,
    output logic            any
);

    logic [NREQ-1:0] req_rot;
    logic [NREQ-1:0] sel_rot;

    // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back.
    assign req_rot = NREQ'({req, req} >> ptr);
    assign sel_rot = req_rot & (~req_rot + NREQ'(1));
    assign sel     = NREQ'({sel_rot, sel_rot} >> (NREQ - int'(ptr)));
    assign any     = |req;

endmodule

// File: rtl/rand_arb.sv
// Round-robin scheduler sharing one 16-bit LFSR core among NREQ requesters,
// with warm-up after enable/reseed and a minimum LFSR advance between grants.
module rand_arb
    import rand_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int WARM = 16,
    parameter int GAP  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_en,
    input  logic            cfg_load,
    input  logic [15:0]     cfg_seed,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [15:0]     rsp_dat,
    output logic            ready,
    output logic            rng_en,
    output logic            rng_load,
    output logic [15:0]     rng_seed,
    input  logic [15:0]     rng_num
);

    localparam int PW = ptr_width(NREQ);

    arb_state_t        state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     nxt_ptr;
    logic [WARM_W-1:0] warm_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              load_pend;
    logic [NREQ-1:0]   sel;
    logic              sel_any;
    logic              gap_ok;

    rr_pick #(
        .NREQ(NREQ),
        .PW  (PW)
    ) u_pick (
        .req(req),
        .ptr(ptr),
        .sel(sel),
        .any(sel_any)
    );

    assign gap_ok = (gap_cnt >= GAP_W'(GAP));

    // Pointer moves to the slot just past the selected requester.
    always_comb begin
        nxt_ptr = '0;
        for (int i = 0; i < NREQ - 1; i++) begin
            if (sel[i]) nxt_ptr = PW'(i + 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            warm_cnt  <= '0;
            gap_cnt   <= GAP_W'(GAP);
            load_pend <= 1'b0;
            gnt       <= '0;
            rsp_dat   <= '0;
            ready     <= 1'b0;
            rng_en    <= 1'b0;
            rng_load  <= 1'b0;
            rng_seed  <= '0;
        end else begin
            gnt      <= '0;
            rng_load <= 1'b0;
            if (cfg_load) rng_seed <= cfg_seed;
            if (rng_en && gap_cnt != GAP_SAT) gap_cnt <= gap_cnt + GAP_W'(1);

            if (state != ST_IDLE && !cfg_en) begin
                state  <= ST_IDLE;
                ready  <= 1'b0;
                rng_en <= 1'b0;
                // A seed taken while shutting down still needs its load pulse later.
                if (cfg_load) load_pend <= 1'b1;
            end else if (state != ST_IDLE && cfg_load) begin
                state     <= ST_LOAD;
                ready     <= 1'b0;
                rng_en    <= 1'b1;
                rng_load  <= 1'b1;
                load_pend <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cfg_en) begin
                            rng_en   <= 1'b1;
                            ready    <= 1'b0;
                            warm_cnt <= '0;
                            if (cfg_load || load_pend) begin
                                state     <= ST_LOAD;
                                rng_load  <= 1'b1;
                                load_pend <= 1'b0;
                            end else begin
                                state <= ST_WARM;
                            end
                        end else if (cfg_load) begin
                            load_pend <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        state    <= ST_WARM;
                        warm_cnt <= '0;
                    end
                    ST_WARM: begin
                        if (warm_cnt == WARM_W'(WARM - 1)) begin
                            state   <= ST_RUN;
                            ready   <= 1'b1;
                            gap_cnt <= GAP_W'(GAP);
                        end else begin
                            warm_cnt <= warm_cnt + WARM_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (sel_any && gap_ok) begin
                            gnt     <= sel;
                            rsp_dat <= rng_num;
                            ptr     <= nxt_ptr;
                            gap_cnt <= '0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rand_arb.sv
// Randomized scoreboard bench for rand_arb: the bench owns the LFSR core and a
// timeline model of when grants are allowed and which requester is next.
`timescale 1ns/1ps
module tb_rand_arb;

    localparam int NREQ = 4;
    localparam int WARM = 16;
    localparam int GAP  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_en = 1'b0;
    logic            cfg_load = 1'b0;
    logic [15:0]     cfg_seed = '0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic [15:0]     rsp_dat;
    logic            ready;
    logic            rng_en;
    logic            rng_load;
    logic [15:0]     rng_seed;
    logic [15:0]     rng_num;

    rand_arb #(
        .NREQ(NREQ),
        .WARM(WARM),
        .GAP (GAP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_en  (cfg_en),
        .cfg_load(cfg_load),
        .cfg_seed(cfg_seed),
        .req     (req),
        .gnt     (gnt),
        .rsp_dat (rsp_dat),
        .ready   (ready),
        .rng_en  (rng_en),
        .rng_load(rng_load),
        .rng_seed(rng_seed),
        .rng_num (rng_num)
    );

    always #5 clk = ~clk;

    logic [15:0] core = 16'h0001;
    assign rng_num = core;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    always @(posedge clk) begin
        if (rng_load)    core <= rng_seed;
        else if (rng_en) core <= lfsr_step(core);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              edge_n;
        logic [NREQ-1:0] g;
        logic [15:0]     d;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] seen_dat[$];
    logic [15:0] run_a[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model: "on" means the generator is enabled; grants are allowed
    // strictly after m_ready_from and no earlier than m_from.
    bit              m_on, m_pend_load, m_granted;
    int              m_ready_from, m_from, m_ptr;
    logic [15:0]     m_seed, m_last_dat;
    logic [NREQ-1:0] pend = '0;
    bit              exp_en, exp_load, exp_ready;

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_pend_load = 0; m_granted = 0;
        m_ready_from = 0; m_from = 0; m_ptr = 0;
        m_seed = '0; m_last_dat = '0;
        exp_en = 0; exp_load = 0; exp_ready = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input int e);
        int pick;
        exp_load = 0;
        m_granted = 0;
        if (cfg_load) m_seed = cfg_seed;
        if (m_on && !cfg_en) begin
            m_on = 0;
            if (cfg_load) m_pend_load = 1;
        end else if (m_on && cfg_load) begin
            exp_load = 1;
            m_ready_from = e + 1 + WARM;
            m_from = 0;
        end else if (!m_on) begin
            if (cfg_en) begin
                m_on = 1;
                m_from = 0;
                if (cfg_load || m_pend_load) begin
                    exp_load = 1;
                    m_pend_load = 0;
                    m_ready_from = e + 1 + WARM;
                end else begin
                    m_ready_from = e + WARM;
                end
            end else if (cfg_load) begin
                m_pend_load = 1;
            end
        end else if (e > m_ready_from && e >= m_from && pend != '0) begin
            pick = -1;
            for (int k = 0; k < NREQ; k++)
                if (pick < 0 && pend[(m_ptr + k) % NREQ]) pick = (m_ptr + k) % NREQ;
            exp_q.push_back('{edge_n: e, g: NREQ'(1) << pick, d: rng_num});
            m_last_dat = rng_num;
            m_ptr = (pick + 1) % NREQ;
            pend[pick] = 1'b0;
            m_from = e + GAP + 1;
            m_granted = 1;
        end
        exp_en = m_on;
        exp_ready = m_on && !exp_load && (e >= m_ready_from);
    endtask

    task automatic checkOutput();
        check_val("ready", ready, exp_ready);
        check_val("rng_en", rng_en, exp_en);
        check_val("rng_load", rng_load, exp_load);
        check_val("rng_seed", rng_seed, m_seed);
        check_val("rsp_dat_hold", rsp_dat, m_last_dat);
    endtask

    // One cycle: check last edge, drive inputs, predict the coming edge.
    task automatic applyStimulus(input logic en, input logic ld, input logic [15:0] seed,
                                 input logic [NREQ-1:0] add);
        checkOutput();
        cfg_en = en;
        cfg_load = ld;
        cfg_seed = seed;
        pend = pend | add;
        req = pend;
        model_edge(cyc + 1);
        @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t x;
        if (!rst) begin
            if (gnt != '0) begin
                seen_dat.push_back(rsp_dat);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_gnt: got gnt=%b at cycle %0d, expected no grant", gnt, cyc);
                end else begin
                    x = exp_q.pop_front();
                    if (x.edge_n != cyc || x.g !== gnt || x.d !== rsp_dat) begin
                        errors++;
                        $display("[TB] FAIL grant: got gnt=%b dat=%h at cycle %0d, expected gnt=%b dat=%h at cycle %0d",
                                 gnt, rsp_dat, cyc, x.g, x.d, x.edge_n);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].edge_n <= cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL missing_gnt: got gnt=0 at cycle %0d, expected gnt=%b dat=%h",
                         cyc, exp_q[0].g, exp_q[0].d);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected $finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dup;
        bit found;
        bit en_lvl;
        logic [NREQ-1:0] add;

        model_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) applyStimulus(1'b0, 1'b0, 16'h0, '0);

        // Seed load together with enable: LOAD pulse, then 17 not-ready cycles.
        applyStimulus(1'b1, 1'b1, 16'hACE1, '0);
        repeat (20) applyStimulus(1'b1, 1'b0, 16'h0, '0);

        applyStimulus(1'b1, 1'b0, 16'h0, 4'b0100);
        repeat (6) applyStimulus(1'b1, 1'b0, 16'h0, '0);
        applyStimulus(1'b1, 1'b0, 16'h0, 4'b1001);
        repeat (8) applyStimulus(1'b1, 1'b0, 16'h0, '0);

        // Full contention: every requester re-requests continuously.
        seen_dat.delete();
        repeat (15) applyStimulus(1'b1, 1'b0, 16'h0, 4'b1111);
        repeat (20) applyStimulus(1'b1, 1'b0, 16'h0, '0);
        dup = 0;
        for (int i = 0; i < seen_dat.size(); i++)
            for (int j = i + 1; j < seen_dat.size(); j++)
                if (seen_dat[i] == seen_dat[j]) dup++;
        check_val("contention_distinct_dups", dup, 0);
        check_val("contention_min_grants", seen_dat.size() >= 5, 1);

        // Reseed with requests pending, twice with the same seed.
        for (int r = 0; r < 2; r++) begin
            seen_dat.delete();
            applyStimulus(1'b1, 1'b1, 16'h1D2B, 4'b0011);
            repeat (26) applyStimulus(1'b1, 1'b0, 16'h0, '0);
            check_val("reseed_grants", seen_dat.size(), 2);
            if (r == 0) run_a = seen_dat;
        end
        for (int i = 0; i < 2; i++)
            check_val("reseed_repeat", seen_dat[i], run_a[i]);

        // Enable drops in the same cycle as an eligible request.
        applyStimulus(1'b0, 1'b0, 16'h0, 4'b0100);
        repeat (4) applyStimulus(1'b0, 1'b0, 16'h0, '0);
        repeat (WARM + 6) applyStimulus(1'b1, 1'b0, 16'h0, '0);

        en_lvl = 1;
        repeat (600) begin
            if (en_lvl) begin
                if ($urandom_range(0, 79) == 0) en_lvl = 0;
            end else if ($urandom_range(0, 5) == 0) begin
                en_lvl = 1;
            end
            add = ($urandom_range(0, 3) == 0) ? (NREQ'(1) << $urandom_range(0, NREQ - 1)) : '0;
            applyStimulus(en_lvl, $urandom_range(0, 89) == 0, 16'($urandom) | 16'h1, add);
        end

        // Reset asserted while a grant is on the bus.
        repeat (WARM + 4) applyStimulus(1'b1, 1'b0, 16'h0, '0);
        found = 0;
        for (int t = 0; t < 60 && !found; t++) begin
            applyStimulus(1'b1, 1'b0, 16'h0, 4'b1111);
            if (m_granted) found = 1;
        end
        check_val("wait_gnt_bound", found, 1);
        #1;
        check_val("gnt_before_rst", gnt != '0, 1);
        cfg_en = 1'b0;
        cfg_load = 1'b0;
        rst = 1'b1;
        #1;
        check_val("rst_gnt", gnt, 0);
        check_val("rst_ready", ready, 0);
        check_val("rst_rng_en", rng_en, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) applyStimulus(1'b0, 1'b0, 16'h0, '0);
        repeat (WARM + 14) applyStimulus(1'b1, 1'b0, 16'h0, '0);

        checkOutput();
        #1;
        check_val("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
